// File: rtl/event_timestamper_pkg.sv
// Shared constants and helpers for the event timestamper slice.
// The timestamp width must match the count width of the free-running counter.
package event_timestamper_pkg;

  localparam int TS_WIDTH   = 32;
  localparam int DROP_CNT_W = 8;

  // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
  function automatic int fill_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/event_timestamper_sync_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on rdata whenever not empty.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module event_timestamper_sync_fifo
  import event_timestamper_pkg::*;
#(
  parameter int WIDTH = TS_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [fill_w(DEPTH)-1:0]  fill
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = fill_w(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] occ;
  logic              wr_en;
  logic              rd_en;

  assign empty = (occ == '0);
  assign full  = (occ == FILL_W'(DEPTH));
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign fill  = occ;
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + FILL_W'(1);
        2'b01:   occ <= occ - FILL_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: empty-ness is carried by occ and rdata is masked.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/event_timestamper.sv
// Captures the counter value on each synchronised rising edge of event_in and queues it.
// Events arriving while the queue is full and not draining are dropped and counted.
module event_timestamper
  import event_timestamper_pkg::*;
#(
  parameter int WIDTH       = TS_WIDTH,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          count,
  input  logic                      event_in,
  output logic [WIDTH-1:0]          ts_data,
  output logic                      ts_valid,
  input  logic                      ts_ready,
  output logic [fill_w(DEPTH)-1:0]  fill,
  output logic                      overflow,
  output logic [DROP_CNT_W-1:0]     drop_cnt,
  input  logic                      clear_ovf
);

  // Handshake: the head entry transfers on any cycle where ts_valid and ts_ready
  // are both high; while ts_valid is high and ts_ready low, ts_data holds steady.

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;
  logic                   event_edge;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic                   drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign event_edge = sync_q[SYNC_STAGES-1] & ~sync_d;
  assign ts_valid   = ~empty;
  assign pop        = ts_valid & ts_ready;
  assign drop       = event_edge & full & ~pop;

  event_timestamper_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (event_edge),
    .wdata (count),
    .pop   (pop),
    .rdata (ts_data),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  // A drop in the same cycle as clear_ovf wins, restarting the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_ovf)
        drop_cnt <= DROP_CNT_W'(1);
      else if (drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end else if (clear_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule
